dm_subword_ram: RTL and testbench

- Parametrised successor to the single-cycle CPU data memory, used by the single-cycle and pipelined MIPS datapaths.
- Adds byte and halfword load/store (sb/sh/sw, lb/lbu/lh/lhu/lw) through per-lane byte enables.
- Adds alignment and range exception detection.
- Replaces instantaneous reset clearing with a sequential clear engine that raises a busy signal.
- Sits between the ALU address output and the writeback mux.

---
 rtl/dm_pkg.sv | 28 ++
 rtl/dm_lane_ctrl.sv | 68 ++++++
 rtl/dm_subword_ram.sv | 136 +++++++++++++
 tb/tb_dm_subword_ram.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared encodings for the sub-word data memory: access sizes, clear-engine
// states and byte-lane enable patterns.
package dm_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } dm_state_e;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // One-hot enable for a single byte lane (lane 0 = bits [7:0]).
    function automatic logic [3:0] byte_lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/dm_lane_ctrl.sv
// Combinational byte-lane steering: store byte enables and merge, load lane
// selection with sign/zero extension, and size/alignment checking.
module dm_lane_ctrl
    import dm_pkg::*;
(
    input  logic [1:0]  off_lo,
    input  logic [1:0]  size,
    input  logic [31:0] write_data,
    input  logic [31:0] old_word,
    input  logic        load_unsigned,
    output logic [3:0]  be,
    output logic [31:0] merged_word,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [31:0] wr_lanes;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte enables and replicated store data; reserved size is flagged here too.
    always_comb begin
        be       = BE_NONE;
        misalign = 1'b0;
        wr_lanes = 32'h0;
        case (size)
            SIZE_BYTE: begin
                be       = byte_lane_be(off_lo);
                wr_lanes = {4{write_data[7:0]}};
            end
            SIZE_HALF: begin
                be       = off_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                misalign = off_lo[0];
                wr_lanes = {2{write_data[15:0]}};
            end
            SIZE_WORD: begin
                be       = BE_WORD;
                misalign = (off_lo != 2'b00);
                wr_lanes = write_data;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_merge
            assign merged_word[gi*LANE_W +: LANE_W] =
                be[gi] ? wr_lanes[gi*LANE_W +: LANE_W] : old_word[gi*LANE_W +: LANE_W];
        end
    endgenerate

    assign byte_sel = old_word[{off_lo, 3'b000} +: 8];
    assign half_sel = off_lo[1] ? old_word[31:16] : old_word[15:0];

    // Load lane selection and extension; word loads pass through unchanged.
    always_comb begin
        load_data = old_word;
        case (size)
            SIZE_BYTE: load_data = {{24{~load_unsigned & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_data = {{16{~load_unsigned & half_sel[15]}}, half_sel};
            default:   load_data = old_word;
        endcase
    end

endmodule

// File: rtl/dm_subword_ram.sv
// Byte-addressable data memory with sub-word loads/stores, address exception
// detection and a sequential clear engine that holds busy after reset.
// Optional build macro DM_WRITE_LOG_EN prints one line per committed store.
module dm_subword_ram
    import dm_pkg::*;
#(
    parameter int          DEPTH     = 3072,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] read_data,
    output logic        addr_exc,
    output logic        busy
);

    localparam int               ADDR_W   = $clog2(DEPTH);
    localparam logic [31:0]      SPAN     = 32'(4 * DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    dm_state_e         state_reg, state_next;
    logic [ADDR_W-1:0] clr_idx_reg, clr_idx_next;

    logic [31:0]       off;
    logic              in_range;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic [31:0]       old_word;
    logic [31:0]       merged_word;
    logic [31:0]       load_data;
    logic [3:0]        be;
    logic              misalign;
    logic              store_en;
    logic              clear_we;

    assign off      = addr - BASE_ADDR;
    assign in_range = (off < SPAN);
    assign word_idx = off[ADDR_W+1:2];
    // Keep the read index inside the array when the address is out of range;
    // the result is masked by addr_exc anyway.
    assign rd_idx   = in_range ? word_idx : '0;

    assign busy     = (state_reg == ST_CLEAR);
    assign addr_exc = misalign | ~in_range;
    assign store_en = mem_write & ~busy & ~addr_exc & ~reset;
    assign clear_we = busy & ~reset;

    dm_lane_ctrl u_lane_ctrl (
        .off_lo        (off[1:0]),
        .size          (size),
        .write_data    (write_data),
        .old_word      (old_word),
        .load_unsigned (load_unsigned),
        .be            (be),
        .merged_word   (merged_word),
        .load_data     (load_data),
        .misalign      (misalign)
    );

    // Storage is split into one 8-bit array per lane so byte enables map
    // directly onto independent write ports.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] lane_mem [DEPTH];

            // Clear engine has priority; otherwise commit enabled store lanes.
            always_ff @(posedge clk) begin
                if (clear_we) begin
                    lane_mem[clr_idx_reg] <= '0;
                end else if (store_en && be[gi]) begin
                    lane_mem[word_idx] <= merged_word[gi*LANE_W +: LANE_W];
                end
            end

            assign old_word[gi*LANE_W +: LANE_W] = lane_mem[rd_idx];
        end
    endgenerate

    // Clear FSM next-state: walk every word once, then return to IDLE.
    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        case (state_reg)
            ST_CLEAR: begin
                clr_idx_next = clr_idx_reg + ADDR_W'(1);
                if (clr_idx_reg == LAST_IDX) begin
                    state_next   = ST_IDLE;
                    clr_idx_next = '0;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                clr_idx_next = clr_idx_reg;
            end
        endcase
    end

    // Clear FSM state register; reset (re)starts the clear from word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_CLEAR;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    // Loads are suppressed while clearing or on any faulting access.
    always_comb begin
        read_data = load_data;
        if (busy || addr_exc) begin
            read_data = 32'h0;
        end
    end

`ifdef DM_WRITE_LOG_EN
    // Grader-format trace of each committed store with the merged word.
    always_ff @(posedge clk) begin
        if (store_en) begin
            $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged_word);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_dm_subword_ram.sv
// Self-checking bench for dm_subword_ram: directed scenarios plus randomized
// accesses against a byte-addressed reference memory.
module tb_dm_subword_ram;

    localparam int          DEPTH = 3072;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic        mem_write = 1'b0;
    logic [1:0]  size = 2'b10;
    logic        load_unsigned = 1'b0;
    logic [31:0] read_data;
    logic        addr_exc;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [31:0] obs_rd;
    logic        obs_exc;

    logic [7:0] mref [4*DEPTH];

    dm_subword_ram #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .addr          (addr),
        .write_data    (write_data),
        .mem_write     (mem_write),
        .size          (size),
        .load_unsigned (load_unsigned),
        .read_data     (read_data),
        .addr_exc      (addr_exc),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic m_exc(input logic [31:0] a, input logic [1:0] s);
        logic [31:0] o;
        o = a - BASE;
        if (s == 2'b11) return 1'b1;
        if (s == 2'b01 && o[0] != 1'b0) return 1'b1;
        if (s == 2'b10 && o[1:0] != 2'b00) return 1'b1;
        if (o >= 32'(4 * DEPTH)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s, input logic u);
        logic [31:0] o;
        logic [31:0] v;
        int nb;
        if (m_exc(a, s)) return 32'h0;
        o  = a - BASE;
        nb = 1 << s;
        v  = 32'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mref[o + i];
        if (nb == 1 && !u && v[7])  v = v | 32'hFFFF_FF00;
        if (nb == 2 && !u && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic void m_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd);
        logic [31:0] o;
        if (m_exc(a, s)) return;
        o = a - BASE;
        for (int i = 0; i < (1 << s); i++) mref[o + i] = wd[8*i +: 8];
    endfunction

    // ---------------- drivers (called at a falling edge) ----------------
    task automatic drive(input logic [31:0] a, input logic [1:0] s, input logic u,
                         input logic w, input logic [31:0] wd);
        addr = a; size = s; load_unsigned = u; mem_write = w; write_data = wd;
        #1;
        obs_rd  = read_data;
        obs_exc = addr_exc;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    // Count falling edges with busy high; must be exactly DEPTH.
    task automatic count_busy(input string name, input bit poke_store);
        int cnt;
        cnt = 0;
        while (busy === 1'b1 && cnt <= DEPTH + 5) begin
            if (poke_store && cnt == 100) begin
                drive(32'h10, 2'b10, 1'b0, 1'b1, 32'hDEAD_BEEF);
                tests++;
                if (obs_rd !== 32'h0) begin
                    fails++;
                    $display("[TB] FAIL %s_busy_read got=%h want=%h", name, obs_rd, 32'h0);
                end
            end else begin
                mem_write = 1'b0;
            end
            cnt++;
            @(negedge clk);
        end
        mem_write = 1'b0;
        tests++;
        if (cnt !== DEPTH) begin
            fails++;
            $display("[TB] FAIL %s_busy_len got=%0d want=%0d", name, cnt, DEPTH);
        end
        $display("[TB] %s busy cycles=%0d", name, cnt);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_busy got=%b want=1", busy);
        end
        reset = 1'b0;
        count_busy("reset_clear", 1'b1);
        for (int i = 0; i < 4 * DEPTH; i++) mref[i] = 8'h00;
        drive(32'h10, 2'b10, 1'b0, 1'b0, 32'h0);
        tests++;
        if (obs_rd !== 32'h0 || obs_exc !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_read10 got=%h/%b want=%h/0", obs_rd, obs_exc, 32'h0);
        end
        $display("[TB] lw 0x10 after clear rd=%h", obs_rd);
    endtask

    task automatic test_word();
        pc = 32'h3004;
        drive(32'h4, 2'b10, 1'b0, 1'b1, 32'h1234_5678);
        step();
        m_store(32'h4, 2'b10, 32'h1234_5678);
        drive(32'h4, 2'b10, 1'b0, 1'b0, 32'h0);
        tests++;
        if (obs_rd !== 32'h1234_5678) begin
            fails++;
            $display("[TB] FAIL word_rt got=%h want=%h", obs_rd, 32'h1234_5678);
        end
        $display("[TB] sw/lw 0x4 rd=%h", obs_rd);
    endtask

    task automatic test_subword_store();
        drive(32'h6, 2'b00, 1'b0, 1'b1, 32'h0000_00AB);
        step();
        m_store(32'h6, 2'b00, 32'h0000_00AB);
        drive(32'h8, 2'b01, 1'b0, 1'b1, 32'h0000_CDEF);
        step();
        m_store(32'h8, 2'b01, 32'h0000_CDEF);
        drive(32'h4, 2'b10, 1'b0, 1'b0, 32'h0);
        tests++;
        if (obs_rd !== 32'h12AB_5678) begin
            fails++;
            $display("[TB] FAIL sb_word1 got=%h want=%h", obs_rd, 32'h12AB_5678);
        end
        $display("[TB] lw 0x4 after sb rd=%h", obs_rd);
        drive(32'h8, 2'b10, 1'b0, 1'b0, 32'h0);
        tests++;
        if (obs_rd !== 32'h0000_CDEF) begin
            fails++;
            $display("[TB] FAIL sh_word2 got=%h want=%h", obs_rd, 32'h0000_CDEF);
        end
        $display("[TB] lw 0x8 after sh rd=%h", obs_rd);
    endtask

    task automatic test_subword_load();
        logic [31:0] a_tab [4] = '{32'h8, 32'h8, 32'h9, 32'h9};
        logic [1:0]  s_tab [4] = '{2'b01, 2'b01, 2'b00, 2'b00};
        logic        u_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] e_tab [4] = '{32'hFFFF_CDEF, 32'h0000_CDEF, 32'hFFFF_FFCD, 32'h0000_00CD};
        for (int i = 0; i < 4; i++) begin
            drive(a_tab[i], s_tab[i], u_tab[i], 1'b0, 32'h0);
            tests++;
            if (obs_rd !== e_tab[i]) begin
                fails++;
                $display("[TB] FAIL subload_%0d got=%h want=%h", i, obs_rd, e_tab[i]);
            end
            $display("[TB] load addr=%h size=%0d uns=%b rd=%h", a_tab[i], s_tab[i], u_tab[i], obs_rd);
        end
    endtask

    task automatic test_exceptions();
        logic [31:0] a_tab [5] = '{32'h2, 32'h5, 32'h8, 32'(4 * DEPTH), 32'hC};
        logic [1:0]  s_tab [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b11};
        logic        w_tab [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] chk   [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] exp_w;
        for (int i = 0; i < 5; i++) begin
            drive(a_tab[i], s_tab[i], 1'b0, w_tab[i], 32'hFFFF_FFFF);
            tests++;
            if (obs_exc !== 1'b1 || obs_rd !== 32'h0) begin
                fails++;
                $display("[TB] FAIL exc_%0d got=%b/%h want=1/%h", i, obs_exc, obs_rd, 32'h0);
            end
            $display("[TB] exc access addr=%h size=%0d exc=%b rd=%h", a_tab[i], s_tab[i], obs_exc, obs_rd);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            exp_w = m_load(chk[i], 2'b10, 1'b0);
            drive(chk[i], 2'b10, 1'b0, 1'b0, 32'h0);
            tests++;
            if (obs_rd !== exp_w) begin
                fails++;
                $display("[TB] FAIL exc_mem_%0d got=%h want=%h", i, obs_rd, exp_w);
            end
            $display("[TB] post-exc lw addr=%h rd=%h", chk[i], obs_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] old_w;
        old_w = m_load(32'h20, 2'b10, 1'b0);
        drive(32'h20, 2'b10, 1'b0, 1'b1, 32'hA5A5_0001);
        tests++;
        if (obs_rd !== old_w) begin
            fails++;
            $display("[TB] FAIL b2b_old got=%h want=%h", obs_rd, old_w);
        end
        m_store(32'h20, 2'b10, 32'hA5A5_0001);
        @(posedge clk);
        #1;
        tests++;
        if (read_data !== 32'hA5A5_0001) begin
            fails++;
            $display("[TB] FAIL b2b_new got=%h want=%h", read_data, 32'hA5A5_0001);
        end
        $display("[TB] sw 0x20 old=%h new=%h", old_w, read_data);
        @(negedge clk);
        drive(32'h21, 2'b00, 1'b1, 1'b1, 32'h0000_0077);
        tests++;
        if (obs_rd !== 32'h0000_0000) begin
            fails++;
            $display("[TB] FAIL b2b_sb_old got=%h want=%h", obs_rd, 32'h0);
        end
        m_store(32'h21, 2'b00, 32'h0000_0077);
        step();
        drive(32'h20, 2'b10, 1'b0, 1'b0, 32'h0);
        tests++;
        if (obs_rd !== 32'hA5A5_7701) begin
            fails++;
            $display("[TB] FAIL b2b_sb_new got=%h want=%h", obs_rd, 32'hA5A5_7701);
        end
        $display("[TB] sb 0x21 then lw 0x20 rd=%h", obs_rd);
    endtask

    task automatic test_random();
        logic [31:0] a, wd, exp_rd;
        logic [1:0]  s;
        logic        u, w, exp_exc;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'(4 * DEPTH) + $urandom_range(0, 15);
                1:       a = 32'(4 * DEPTH) - 32'($urandom_range(1, 8));
                default: a = $urandom_range(0, 63);
            endcase
            s  = 2'($urandom_range(0, 3));
            if (s == 2'b10 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            u  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            pc = 32'h0040_0000 + 32'(4 * i);
            exp_exc = m_exc(a, s);
            exp_rd  = m_load(a, s, u);
            drive(a, s, u, w, wd);
            tests++;
            if (obs_exc !== exp_exc || obs_rd !== exp_rd) begin
                fails++;
                $display("[TB] FAIL rand_%0d addr=%h size=%0d got=%h/%b want=%h/%b",
                         i, a, s, obs_rd, obs_exc, exp_rd, exp_exc);
            end
            $display("[TB] rand %0d addr=%h size=%0d uns=%b wr=%b wd=%h rd=%h exc=%b",
                     i, a, s, u, w, wd, obs_rd, obs_exc);
            step();
            if (w) m_store(a, s, wd);
        end
    endtask

    task automatic test_reset_mid_clear();
        int hi;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy === 1'b1) hi++;
            @(negedge clk);
        end
        tests++;
        if (hi !== 100) begin
            fails++;
            $display("[TB] FAIL midclr_pre got=%0d want=%0d", hi, 100);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        count_busy("mid_clear_restart", 1'b0);
        for (int i = 0; i < 4 * DEPTH; i++) mref[i] = 8'h00;
        drive(32'h20, 2'b10, 1'b0, 1'b0, 32'h0);
        tests++;
        if (obs_rd !== 32'h0) begin
            fails++;
            $display("[TB] FAIL midclr_read got=%h want=%h", obs_rd, 32'h0);
        end
        $display("[TB] lw 0x20 after restart rd=%h", obs_rd);
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword_store();
        test_subword_load();
        test_exceptions();
        test_back_to_back();
        test_random();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
